// File: rtl/param_pipeline_cpu_pkg.sv
// Shared definitions for the parameterised three-stage pipeline CPU:
// opcode values, FSM state encoding and width-derivation helpers.
package param_pipeline_cpu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int instr_w(input int raw);
    return 2 + 3 * raw;
  endfunction

  function automatic int ld_aw(input int pc_w, input int raw);
    return max_int(pc_w, 2 * raw);
  endfunction

  function automatic int ld_dw(input int iw, input int dw);
    return max_int(iw, dw);
  endfunction

endpackage

// File: rtl/param_pipeline_cpu_if.sv
// Host-side bus of the pipeline CPU: start, program/data load port,
// register debug read and run status.
interface param_pipeline_cpu_if
  import param_pipeline_cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 4,
  parameter int IMEM_DEPTH = 16
);

  localparam int RAW   = addr_w(NUM_REGS);
  localparam int PC_W  = addr_w(IMEM_DEPTH);
  localparam int LD_AW = ld_aw(PC_W, RAW);
  localparam int LD_DW = ld_dw(instr_w(RAW), DATA_W);

  logic              start;
  logic              prog_we;
  logic              prog_sel;
  logic [LD_AW-1:0]  prog_addr;
  logic [LD_DW-1:0]  prog_data;
  logic [RAW-1:0]    dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              busy;
  logic              halted;
  logic              ovf;
  logic [PC_W-1:0]   pc;
  logic [15:0]       retired;

  modport master (
    output start, prog_we, prog_sel, prog_addr, prog_data, dbg_addr,
    input  dbg_data, busy, halted, ovf, pc, retired
  );

  modport slave (
    input  start, prog_we, prog_sel, prog_addr, prog_data, dbg_addr,
    output dbg_data, busy, halted, ovf, pc, retired
  );

endinterface

// File: rtl/param_pipeline_cpu_alu.sv
// Combinational ADD/SUB unit; cout is the carry out for ADD and the
// borrow for SUB.
module ppc_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] y,
  output logic              cout
);

  logic [DATA_W:0] sum;

  // One extra bit captures carry (ADD) or borrow (SUB) in the MSB.
  always_comb begin
    if (sub) sum = {1'b0, a} - {1'b0, b};
    else     sum = {1'b0, a} + {1'b0, b};
  end

  assign y    = sum[DATA_W-1:0];
  assign cout = sum[DATA_W];

endmodule

// File: rtl/param_pipeline_cpu.sv
// Three-stage (IF / EX / WB) parameterised CPU with ADD, SUB, LOAD and
// HALT, WB-to-EX forwarding, loadable instruction and data memories.
module param_pipeline_cpu
  import param_pipeline_cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 4,
  parameter int IMEM_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  param_pipeline_cpu_if.slave  bus
);

  localparam int RAW        = addr_w(NUM_REGS);
  localparam int PC_W       = addr_w(IMEM_DEPTH);
  localparam int INSTR_W    = instr_w(RAW);
  localparam int DM_AW      = 2 * RAW;
  localparam int DMEM_DEPTH = 1 << DM_AW;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              state_q, state_d;
  logic                start_ok;
  logic                fetch_en;
  logic                load_ok;

  logic [PC_W-1:0]     pc_q;
  logic                ovf_q;
  logic [15:0]         retired_q;

  logic [INSTR_W-1:0]  imem [IMEM_DEPTH];
  logic [DATA_W-1:0]   dmem [DMEM_DEPTH];
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic [INSTR_W-1:0]  instr_p0;
  logic                vld_p0;
  logic [DATA_W-1:0]   res_p1;
  logic [RAW-1:0]      rd_p1;
  logic                vld_p1;

  logic [1:0]          op_ex;
  logic [RAW-1:0]      rd_ex, rs1_ex, rs2_ex;
  logic [DATA_W-1:0]   opa_ex, opb_ex, alu_y, res_ex;
  logic                alu_c;
  logic                halt_ex, wb_ex, arith_ex;

  assign load_ok = (state_q == ST_IDLE) || (state_q == ST_HALTED);

  // Host loads into instruction or data memory while the core is stopped.
  always_ff @(posedge clk) begin
    if (load_ok && bus.prog_we) begin
      if (!bus.prog_sel) imem[bus.prog_addr[PC_W-1:0]] <= bus.prog_data[INSTR_W-1:0];
      else               dmem[bus.prog_addr[DM_AW-1:0]] <= bus.prog_data[DATA_W-1:0];
    end
  end

  // ---- EX stage: decode, forward from WB, ALU / memory read ----
  assign op_ex    = instr_p0[INSTR_W-1 -: 2];
  assign rd_ex    = instr_p0[3*RAW-1 -: RAW];
  assign rs1_ex   = instr_p0[2*RAW-1 -: RAW];
  assign rs2_ex   = instr_p0[RAW-1:0];
  assign opa_ex   = (vld_p1 && (rd_p1 == rs1_ex)) ? res_p1 : regs[rs1_ex];
  assign opb_ex   = (vld_p1 && (rd_p1 == rs2_ex)) ? res_p1 : regs[rs2_ex];
  assign halt_ex  = vld_p0 && (op_ex == OP_HALT);
  assign wb_ex    = vld_p0 && (op_ex != OP_HALT);
  assign arith_ex = vld_p0 && ((op_ex == OP_ADD) || (op_ex == OP_SUB));

  ppc_alu #(.DATA_W(DATA_W)) u_alu (
    .a    (opa_ex),
    .b    (opb_ex),
    .sub  (op_ex == OP_SUB),
    .y    (alu_y),
    .cout (alu_c)
  );

  assign res_ex = (op_ex == OP_LOAD) ? dmem[{rs1_ex, rs2_ex}] : alu_y;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a HALT reaching EX stops fetch and drains WB.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          state_d  = ST_RUN;
          start_ok = 1'b1;
        end
      end
      ST_RUN:   if (halt_ex) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HALTED;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign fetch_en = (state_q == ST_RUN) && !halt_ex;

  // Pipeline control: pc, valids, sticky overflow and retire counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      ovf_q     <= 1'b0;
      retired_q <= '0;
    end else if (start_ok) begin
      pc_q      <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      ovf_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      vld_p0 <= fetch_en;
      vld_p1 <= wb_ex;
      if (fetch_en)           pc_q      <= pc_q + 1'b1;
      if (arith_ex && alu_c)  ovf_q     <= 1'b1;
      if (vld_p1)             retired_q <= sat_inc16(retired_q);
    end
  end

  // ---- IF -> EX and EX -> WB data registers ----
  always_ff @(posedge clk) begin
    if (fetch_en) instr_p0 <= imem[pc_q];
    res_p1 <= res_ex;
    rd_p1  <= rd_ex;
  end

  // ---- WB stage: register-file write ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (vld_p1) begin
      regs[rd_p1] <= res_p1;
    end
  end

  assign bus.dbg_data = regs[bus.dbg_addr];
  assign bus.busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.halted   = (state_q == ST_HALTED);
  assign bus.ovf      = ovf_q;
  assign bus.pc       = pc_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_param_pipeline_cpu.sv
// Directed testbench for param_pipeline_cpu (DATA_W=8, NUM_REGS=4,
// IMEM_DEPTH=16) with hand-computed expected values.
module tb_param_pipeline_cpu;

  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 4;
  localparam int IMEM_DEPTH = 16;

  localparam logic [7:0] I_LD1  = 8'h91; // LOAD R1,[0,1]
  localparam logic [7:0] I_LD2  = 8'hA2; // LOAD R2,[0,2]
  localparam logic [7:0] I_ADD3 = 8'h36; // ADD  R3,R1,R2
  localparam logic [7:0] I_HALT = 8'hC0; // HALT
  localparam logic [7:0] I_SUB0 = 8'h49; // SUB  R0,R2,R1
  localparam logic [7:0] I_LD13 = 8'h93; // LOAD R1,[0,3]
  localparam logic [7:0] I_LD00 = 8'h80; // LOAD R0,[0,0]
  localparam logic [7:0] I_INC0 = 8'h01; // ADD  R0,R0,R1

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  param_pipeline_cpu_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IMEM_DEPTH(IMEM_DEPTH)) bus ();

  param_pipeline_cpu #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IMEM_DEPTH(IMEM_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input int addr, input logic [7:0] data);
    bus.prog_sel  = sel;
    bus.prog_addr = addr[3:0];
    bus.prog_data = data;
    bus.prog_we   = 1'b1;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic get_reg(input int idx, output logic [7:0] v);
    bus.dbg_addr = idx[1:0];
    #1;
    v = bus.dbg_data;
  endtask

  task automatic wait_halted(input int max_cycles);
    for (int i = 0; i < max_cycles && !bus.halted; i++) tick();
    total++;
    if (bus.halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_timeout halted=%b want=1", bus.halted);
    end
  endtask

  task automatic load_prog1();
    load(1'b0, 0, I_LD1);
    load(1'b0, 1, I_LD2);
    load(1'b0, 2, I_ADD3);
    load(1'b0, 3, I_HALT);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b0;
    tick();
    tick();
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.halted !== 1'b0)  begin bad++; $display("FAIL rst_halted got=%b want=0", bus.halted); end
    total++; if (bus.pc !== 4'd0)      begin bad++; $display("FAIL rst_pc got=%0d want=0", bus.pc); end
    total++; if (bus.ovf !== 1'b0)     begin bad++; $display("FAIL rst_ovf got=%b want=0", bus.ovf); end
    total++; if (bus.retired !== 16'd0) begin bad++; $display("FAIL rst_retired got=%0d want=0", bus.retired); end
    rst = 1'b1;
    tick();
    for (int r = 0; r < NUM_REGS; r++) begin
      get_reg(r, v);
      total++; if (v !== 8'd0) begin bad++; $display("FAIL rst_reg%0d got=%0d want=0", r, v); end
    end
  endtask

  task automatic test_forward();
    logic [7:0] v;
    load(1'b1, 1, 8'd50);
    load(1'b1, 2, 8'd25);
    load_prog1();
    pulse_start();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL fwd_busy got=%b want=1", bus.busy); end
    total++; if (bus.pc !== 4'd0)   begin bad++; $display("FAIL fwd_pc0 got=%0d want=0", bus.pc); end
    wait_halted(20);
    get_reg(3, v);
    total++; if (v !== 8'd75) begin bad++; $display("FAIL fwd_r3 got=%0d want=75", v); end
    get_reg(1, v);
    total++; if (v !== 8'd50) begin bad++; $display("FAIL fwd_r1 got=%0d want=50", v); end
    get_reg(2, v);
    total++; if (v !== 8'd25) begin bad++; $display("FAIL fwd_r2 got=%0d want=25", v); end
    total++; if (bus.retired !== 16'd3) begin bad++; $display("FAIL fwd_retired got=%0d want=3", bus.retired); end
    total++; if (bus.ovf !== 1'b0)      begin bad++; $display("FAIL fwd_ovf got=%b want=0", bus.ovf); end
    total++; if (bus.pc !== 4'd4)       begin bad++; $display("FAIL fwd_pc got=%0d want=4", bus.pc); end
    total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL fwd_busy_end got=%b want=0", bus.busy); end
  endtask

  task automatic test_sub_ovf();
    logic [7:0] v;
    load(1'b0, 0, I_SUB0);
    load(1'b0, 1, I_HALT);
    pulse_start();
    wait_halted(20);
    get_reg(0, v);
    total++; if (v !== 8'd231)          begin bad++; $display("FAIL sub_r0 got=%0d want=231", v); end
    total++; if (bus.ovf !== 1'b1)      begin bad++; $display("FAIL sub_ovf got=%b want=1", bus.ovf); end
    total++; if (bus.retired !== 16'd1) begin bad++; $display("FAIL sub_retired got=%0d want=1", bus.retired); end
    total++; if (bus.pc !== 4'd2)       begin bad++; $display("FAIL sub_pc got=%0d want=2", bus.pc); end
    pulse_start();
    total++; if (bus.ovf !== 1'b0)      begin bad++; $display("FAIL restart_ovf got=%b want=0", bus.ovf); end
    total++; if (bus.retired !== 16'd0) begin bad++; $display("FAIL restart_retired got=%0d want=0", bus.retired); end
    wait_halted(20);
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    load(1'b1, 0, 8'd0);
    load(1'b1, 3, 8'd1);
    load(1'b0, 0, I_LD13);
    load(1'b0, 1, I_LD00);
    load(1'b0, 2, I_HALT);
    pulse_start();
    wait_halted(20);
    get_reg(1, v);
    total++; if (v !== 8'd1) begin bad++; $display("FAIL wrap_r1 got=%0d want=1", v); end
    for (int a = 0; a < IMEM_DEPTH; a++) load(1'b0, a, I_INC0);
    pulse_start();
    for (int m = 1; m <= 22; m++) begin
      tick();
      total++;
      if (bus.pc !== 4'(m % 16)) begin bad++; $display("FAIL wrap_pc cyc=%0d got=%0d want=%0d", m, bus.pc, m % 16); end
      if (m >= 2) begin
        get_reg(0, v);
        total++;
        if (v !== 8'(m - 2)) begin bad++; $display("FAIL wrap_r0 cyc=%0d got=%0d want=%0d", m, v, m - 2); end
      end
    end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL wrap_busy got=%b want=1", bus.busy); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    load_prog1();
    pulse_start();
    tick();
    tick();
    tick();
    get_reg(1, v);
    total++; if (v !== 8'd50) begin bad++; $display("FAIL mid_r1_pre got=%0d want=50", v); end
    rst = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
    total++; if (bus.pc !== 4'd0)   begin bad++; $display("FAIL mid_pc got=%0d want=0", bus.pc); end
    for (int r = 0; r < NUM_REGS; r++) begin
      get_reg(r, v);
      total++; if (v !== 8'd0) begin bad++; $display("FAIL mid_reg%0d got=%0d want=0", r, v); end
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    for (int r = 0; r < NUM_REGS; r++) begin
      get_reg(r, v);
      total++; if (v !== 8'd0) begin bad++; $display("FAIL mid_post_reg%0d got=%0d want=0", r, v); end
    end
    total++; if (bus.retired !== 16'd0) begin bad++; $display("FAIL mid_retired got=%0d want=0", bus.retired); end
    total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL mid_post_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] v;
    pulse_start();
    tick();
    load(1'b0, 0, I_HALT);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++; if (bus.pc !== 4'd3) begin bad++; $display("FAIL ign_pc got=%0d want=3", bus.pc); end
    wait_halted(20);
    get_reg(3, v);
    total++; if (v !== 8'd75)           begin bad++; $display("FAIL ign_r3 got=%0d want=75", v); end
    total++; if (bus.retired !== 16'd3) begin bad++; $display("FAIL ign_retired got=%0d want=3", bus.retired); end
    pulse_start();
    wait_halted(20);
    total++; if (bus.retired !== 16'd3) begin bad++; $display("FAIL ign_rerun_retired got=%0d want=3", bus.retired); end
    total++; if (bus.pc !== 4'd4)       begin bad++; $display("FAIL ign_rerun_pc got=%0d want=4", bus.pc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_sel  = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.dbg_addr  = '0;
    test_reset();
    test_forward();
    test_sub_ovf();
    test_wrap();
    test_reset_mid();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
